regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (we / rZ_address / rZ) among NREQ write-back requesters, e.g. ALU, load unit and multiplier.
- Round-robin arbitration with a per-requester valid/ready handshake, then one registered output stage that drives the register file.
- Keeps a pending-write scoreboard so issue logic can detect RAW hazards on registers still waiting for write-back.

---
 rtl/regfile_wb_arbiter.sv | 135 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// Round-robin grant among nreq requesters, one registered output stage,
// and a pending-write scoreboard used by issue logic for RAW detection.
module regfile_wb_arbiter #(
    parameter int unsigned dtype    = 16,
    parameter int unsigned nregs    = 8,
    parameter int unsigned addr_len = $clog2(nregs),
    parameter int unsigned nreq     = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     hold,
    input  logic [nreq-1:0]          req_valid,
    output logic [nreq-1:0]          req_ready,
    input  logic [nreq*addr_len-1:0] req_addr,
    input  logic [nreq*dtype-1:0]    req_data,
    input  logic                     pend_set,
    input  logic [addr_len-1:0]      pend_addr,
    output logic [nregs-1:0]         pending,
    output logic                     we,
    output logic [addr_len-1:0]      rZ_address,
    output logic [dtype-1:0]         rZ,
    output logic [$clog2(nreq)-1:0]  grant_id
);

    localparam int unsigned id_len = $clog2(nreq);

    logic [id_len-1:0]   ptr_q, ptr_d;
    logic [nreq-1:0]     grant;
    logic [id_len-1:0]   grant_idx;
    logic                grant_found;
    logic [id_len-1:0]   cand;
    int unsigned         scan;
    logic [addr_len-1:0] sel_addr;
    logic [dtype-1:0]    sel_data;
    logic                we_q;
    logic [addr_len-1:0] addr_q;
    logic [dtype-1:0]    data_q;
    logic [id_len-1:0]   gid_q;
    logic [nregs-1:0]    pend_q, pend_d;

    // Round-robin search starting at the pointer; first valid requester wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        scan        = 0;
        cand        = '0;
        if (!hold && !reset) begin
            for (int unsigned k = 0; k < nreq; k++) begin
                scan = 32'(ptr_q) + k;
                if (scan >= nreq) begin
                    scan = scan - nreq;
                end
                cand = scan[id_len-1:0];
                if (!grant_found && req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant[cand] = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    assign req_ready = grant;

    // Pick the granted requester's address/data slice.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < nreq; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*addr_len +: addr_len];
                sel_data = req_data[i*dtype +: dtype];
            end
        end
    end

    // Pointer moves just past the requester that transferred.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_found) begin
            ptr_d = (grant_idx == id_len'(nreq - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Output stage and pointer; a write to register 0 is consumed but not enabled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            gid_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (grant_found) begin
                we_q   <= (sel_addr != '0);
                addr_q <= sel_addr;
                data_q <= sel_data;
                gid_q  <= grant_idx;
            end else begin
                we_q <= 1'b0;
            end
        end
    end

    // Scoreboard next state: commit clears first, then a new set overrides it.
    always_comb begin
        pend_d = pend_q;
        if (we_q) begin
            pend_d[addr_q] = 1'b0;
        end
        if (pend_set && (pend_addr != '0)) begin
            pend_d[pend_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pending    = pend_q;
    assign we         = we_q;
    assign rZ_address = addr_q;
    assign rZ         = data_q;
    assign grant_id   = gid_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int DT = 16;
    localparam int NR = 8;
    localparam int AL = 3;
    localparam int NQ = 3;
    localparam int GL = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              hold = 1'b0;
    logic [NQ-1:0]     req_valid = '0;
    logic [NQ-1:0]     req_ready;
    logic [NQ*AL-1:0]  req_addr = '0;
    logic [NQ*DT-1:0]  req_data = '0;
    logic              pend_set = 1'b0;
    logic [AL-1:0]     pend_addr = '0;
    logic [NR-1:0]     pending;
    logic              we;
    logic [AL-1:0]     rZ_address;
    logic [DT-1:0]     rZ;
    logic [GL-1:0]     grant_id;

    always #5 clock = ~clock;

    regfile_wb_arbiter #(
        .dtype   (DT),
        .nregs   (NR),
        .addr_len(AL),
        .nreq    (NQ)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .hold      (hold),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .pending   (pending),
        .we        (we),
        .rZ_address(rZ_address),
        .rZ        (rZ),
        .grant_id  (grant_id)
    );

    // Requester-side stimulus
    bit v[NQ];
    int a[NQ];
    int d[NQ];

    // Reference model state
    int ptr_m;
    bit we_m;
    int addr_m;
    int data_m;
    int gid_m;
    bit pend_m[NR];
    int last_gnt;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NR-1:0] pend_vec();
        logic [NR-1:0] r;
        r = '0;
        for (int k = 0; k < NR; k++) r[k] = pend_m[k];
        return r;
    endfunction

    task automatic model_reset();
        ptr_m  = 0;
        we_m   = 1'b0;
        addr_m = 0;
        data_m = 0;
        gid_m  = 0;
        for (int k = 0; k < NR; k++) pend_m[k] = 1'b0;
    endtask

    // One cycle: drive at negedge, check, advance model at posedge.
    task automatic step();
        int g;
        logic [NQ-1:0] er;
        for (int i = 0; i < NQ; i++) begin
            req_valid[i] = v[i];
            req_addr[i*AL +: AL] = AL'(a[i]);
            req_data[i*DT +: DT] = DT'(d[i]);
        end
        #1;
        g = -1;
        if (!hold) begin
            for (int k = 0; k < NQ; k++) begin
                if (g < 0 && v[(ptr_m + k) % NQ]) g = (ptr_m + k) % NQ;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check_eq("req_ready", 32'(req_ready), 32'(er));
        check_eq("we", 32'(we), 32'(we_m));
        if (we_m) begin
            check_eq("rZ_address", 32'(rZ_address), 32'(addr_m));
            check_eq("rZ", 32'(rZ), 32'(data_m));
            check_eq("grant_id", 32'(grant_id), 32'(gid_m));
        end
        check_eq("pending", 32'(pending), 32'(pend_vec()));
        @(posedge clock);
        if (we_m) pend_m[addr_m] = 1'b0;
        if (pend_set && pend_addr != 0) pend_m[pend_addr] = 1'b1;
        if (g >= 0) begin
            we_m   = (a[g] != 0);
            addr_m = a[g];
            data_m = d[g];
            gid_m  = g;
            ptr_m  = (g + 1) % NQ;
            v[g]   = 1'b0;
        end else begin
            we_m = 1'b0;
        end
        last_gnt = g;
        @(negedge clock);
    endtask

    task automatic all_valid(input int base);
        for (int i = 0; i < NQ; i++) begin
            v[i] = 1'b1;
            a[i] = base + i;
            d[i] = 16'hA000 + i;
        end
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < NQ; i++) begin
            v[i] = 1'b0;
            a[i] = 0;
            d[i] = 0;
        end
        last_gnt = -1;

        // Reset: outputs low and no grants even with requests present
        req_valid = '1;
        #2;
        check_eq("rst_ready", 32'(req_ready), 32'h0);
        check_eq("rst_we", 32'(we), 32'h0);
        check_eq("rst_pending", 32'(pending), 32'h0);
        req_valid = '0;
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) step();

        // Single requester
        v[1] = 1'b1; a[1] = 3; d[1] = 16'hBEEF;
        step();
        check_eq("single_gnt", 32'(last_gnt), 32'd1);
        step();
        step();

        // Register 0 drop; pointer then favours requester 0
        v[2] = 1'b1; a[2] = 0; d[2] = 16'h1234;
        step();
        check_eq("r0_gnt", 32'(last_gnt), 32'd2);
        step();

        // Round robin with all requesters continuously valid
        for (int c = 0; c < 6; c++) begin
            all_valid(1);
            step();
            check_eq("rr_order", 32'(last_gnt), 32'(c % 3));
        end
        step();

        // Scoreboard set then clear by commit
        pend_set = 1'b1; pend_addr = 3'd5;
        step();
        pend_set = 1'b0;
        check_eq("sb_set", 32'(pending), 32'h20);
        v[0] = 1'b1; a[0] = 5; d[0] = 16'h5555;
        step();
        step();
        check_eq("sb_clear", 32'(pending), 32'h00);

        // Set coincides with commit to the same register
        pend_set = 1'b1; pend_addr = 3'd5;
        step();
        pend_set = 1'b0;
        v[0] = 1'b1; a[0] = 5; d[0] = 16'h6666;
        step();
        pend_set = 1'b1; pend_addr = 3'd5;
        step();
        pend_set = 1'b0;
        check_eq("sb_collide", 32'(pending), 32'h20);
        step();

        // hold blocks grants but the in-flight write completes
        all_valid(1);
        step();
        hold = 1'b1;
        all_valid(1);
        step();
        hold = 1'b0;

        // Asynchronous reset mid-cycle with a write in flight
        pend_set = 1'b1; pend_addr = 3'd3;
        all_valid(4);
        step();
        pend_set = 1'b0;
        all_valid(4);
        step();
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_we", 32'(we), 32'h0);
        check_eq("arst_pending", 32'(pending), 32'h0);
        check_eq("arst_gid", 32'(grant_id), 32'h0);
        check_eq("arst_rz", 32'(rZ), 32'h0);
        check_eq("arst_ready", 32'(req_ready), 32'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        all_valid(1);
        step();
        check_eq("arst_ptr", 32'(last_gnt), 32'd0);

        // Randomised traffic honouring the valid-hold rule
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NQ; i++) begin
                if (!v[i] && $urandom_range(0, 2) != 0) begin
                    v[i] = 1'b1;
                    a[i] = int'($urandom_range(0, NR - 1));
                    d[i] = int'($urandom_range(0, 16'hFFFF));
                end
            end
            hold      = ($urandom_range(0, 5) == 0);
            pend_set  = ($urandom_range(0, 2) == 0);
            pend_addr = AL'($urandom_range(0, NR - 1));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
